// File: rtl/ccff_chain_loader_pkg.sv
// Shared types and CRC helper for the CCFF chain loader.
// State encoding, CRC-16-CCITT constants and the single-bit CRC step.
package ccff_chain_loader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    VERIFY = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // One bit-serial CRC-16-CCITT step with MSB feedback.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/ccff_crc16_serial.sv
// Bit-serial CRC-16-CCITT accumulator with synchronous clear.
// Instanced once for the loaded stream and once for the recirculated tail stream.
module ccff_crc16_serial
  import ccff_chain_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= CRC16_INIT;
    end else if (clr) begin
      crc <= CRC16_INIT;
    end else if (en) begin
      crc <= crc16_step(crc, din);
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Serial loader for one CCFF chain: shifts config words in LSB-first, then
// recirculates the chain once and compares head/tail CRCs.
module ccff_chain_loader
  import ccff_chain_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 16,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clock,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              shift_en,
  output logic              config_enable,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(CHAIN_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(WORD_W - 1);

  state_t            state;
  logic [WORD_W-1:0] buf_word;
  logic              buf_full;
  logic [IDX_W-1:0]  bit_idx;
  logic [CNT_W-1:0]  acc_cnt;
  logic [CNT_W-1:0]  sh_cnt;
  logic              err_sticky;
  logic [15:0]       load_crc;
  logic [15:0]       tail_crc;

  logic loading;
  logic verifying;
  logic load_shift;
  logic last_bit;
  logic accept;
  logic crc_clr;
  logic crc_mismatch;

  assign loading    = (state == LOAD);
  assign verifying  = (state == VERIFY);
  assign load_shift = loading & buf_full;
  // The buffer empties either at the word's last bit or at the chain's last bit,
  // whichever comes first; trailing bits of the final word are never shifted.
  assign last_bit   = buf_full & ((bit_idx == LAST_IDX) | (sh_cnt == LAST_SHIFT));
  assign word_ready = loading & (~buf_full | last_bit) & (acc_cnt < FULL_CNT);
  assign accept     = word_valid & word_ready;
  assign crc_clr    = (state == IDLE) & start & ~abort;

  assign shift_en      = load_shift | verifying;
  assign ccff_head     = verifying ? ccff_tail : (load_shift ? buf_word[bit_idx] : 1'b0);
  assign config_enable = loading | verifying;
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
  assign crc_mismatch  = (state == DONE) & (load_crc != tail_crc);
  assign error         = err_sticky | crc_mismatch;

  // Load/verify sequencer with word buffer, bit index and shift counters.
  always_ff @(posedge prog_clock or posedge prog_reset) begin
    if (prog_reset) begin
      state      <= IDLE;
      buf_word   <= '0;
      buf_full   <= 1'b0;
      bit_idx    <= '0;
      acc_cnt    <= '0;
      sh_cnt     <= '0;
      err_sticky <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state      <= LOAD;
            err_sticky <= 1'b0;
            buf_full   <= 1'b0;
            bit_idx    <= '0;
            acc_cnt    <= '0;
            sh_cnt     <= '0;
          end
        end
        LOAD: begin
          if (abort) begin
            state      <= IDLE;
            err_sticky <= 1'b1;
            buf_full   <= 1'b0;
          end else begin
            if (accept) begin
              buf_word <= word_data;
              buf_full <= 1'b1;
              bit_idx  <= '0;
              if (int'(acc_cnt) + WORD_W >= CHAIN_LEN) begin
                acc_cnt <= FULL_CNT;
              end else begin
                acc_cnt <= acc_cnt + CNT_W'(WORD_W);
              end
            end else if (last_bit) begin
              buf_full <= 1'b0;
            end else if (load_shift) begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
            if (load_shift) begin
              if (sh_cnt == LAST_SHIFT) begin
                state  <= VERIFY;
                sh_cnt <= '0;
              end else begin
                sh_cnt <= sh_cnt + CNT_W'(1);
              end
            end
          end
        end
        VERIFY: begin
          if (abort) begin
            state      <= IDLE;
            err_sticky <= 1'b1;
          end else if (sh_cnt == LAST_SHIFT) begin
            state <= DONE;
          end else begin
            sh_cnt <= sh_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state      <= IDLE;
          err_sticky <= err_sticky | crc_mismatch;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  ccff_crc16_serial u_load_crc (
    .clk (prog_clock),
    .rst (prog_reset),
    .clr (crc_clr),
    .en  (load_shift),
    .din (ccff_head),
    .crc (load_crc)
  );

  ccff_crc16_serial u_tail_crc (
    .clk (prog_clock),
    .rst (prog_reset),
    .clr (crc_clr),
    .en  (verifying),
    .din (ccff_tail),
    .crc (tail_crc)
  );

endmodule
